// File: rtl/vdf_sq_ctrl_if.sv
// Squarer handshake bundle: the controller issues operands on o_sq_* and
// receives results on i_sq_*; names follow the controller's point of view.
interface vdf_sq_ctrl_if #(
    parameter int DAT_BITS = 1044
);
    logic                o_sq_val;
    logic                o_sq_reduce_only;
    logic [DAT_BITS-1:0] o_sq_dat;
    logic                i_sq_val;
    logic [DAT_BITS-1:0] i_sq_dat;

    modport master (
        output o_sq_val, o_sq_reduce_only, o_sq_dat,
        input  i_sq_val, i_sq_dat
    );

    modport slave (
        input  o_sq_val, o_sq_reduce_only, o_sq_dat,
        output i_sq_val, i_sq_dat
    );
endinterface

// File: rtl/vdf_sq_ctrl.sv
// VDF squaring controller: runs T squarings through an external squarer,
// then one reduce-only pass, with watchdog timeout and abort.
module vdf_sq_ctrl #(
    parameter int WORD_BITS = 17,
    parameter int NUM_WORDS = 57,
    parameter int COEF_BITS = WORD_BITS + 1,
    parameter int I_WORD    = NUM_WORDS + 1,
    parameter int ITER_BITS = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [ITER_BITS-1:0]        i_iters,
    input  logic [I_WORD*COEF_BITS-1:0] i_dat,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic [I_WORD*COEF_BITS-1:0] o_dat,
    output logic [ITER_BITS-1:0]        o_iter_cnt,
    vdf_sq_ctrl_if.master               sq
);
    localparam int DW      = I_WORD * COEF_BITS;
    localparam int WD_BITS = $clog2(TIMEOUT + 1);
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RED_ISSUE,
        RED_WAIT,
        DONE
    } state_t;

    state_t               state;
    logic [DW-1:0]        opnd;
    logic [ITER_BITS-1:0] iters;
    logic [WD_BITS-1:0]   wdog;
    logic [ITER_BITS-1:0] cnt_inc;

    assign sq.o_sq_dat = opnd;

    // Saturating increment of the completed-squaring count.
    always_comb begin
        cnt_inc = (o_iter_cnt == '1) ? o_iter_cnt : o_iter_cnt + 1'b1;
    end

    // Job FSM; all outputs registered alongside the state.
    // The watchdog is zeroed on entry to an issue state and counts from the
    // issue cycle, so a timeout lands o_done exactly TIMEOUT cycles after
    // the o_sq_val pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            opnd                <= '0;
            iters               <= '0;
            wdog                <= '0;
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_err               <= 1'b0;
            o_dat               <= '0;
            o_iter_cnt          <= '0;
            sq.o_sq_val         <= 1'b0;
            sq.o_sq_reduce_only <= 1'b0;
        end else begin
            o_done              <= 1'b0;
            sq.o_sq_val         <= 1'b0;
            sq.o_sq_reduce_only <= 1'b0;
            if (i_abort && state != IDLE) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            opnd        <= i_dat;
                            iters       <= i_iters;
                            o_iter_cnt  <= '0;
                            o_err       <= 1'b0;
                            o_busy      <= 1'b1;
                            wdog        <= '0;
                            sq.o_sq_val <= 1'b1;
                            if (i_iters == '0) begin
                                state               <= RED_ISSUE;
                                sq.o_sq_reduce_only <= 1'b1;
                            end else begin
                                state <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        wdog  <= wdog + 1'b1;
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (sq.i_sq_val) begin
                            opnd        <= sq.i_sq_dat;
                            o_iter_cnt  <= cnt_inc;
                            wdog        <= '0;
                            sq.o_sq_val <= 1'b1;
                            if (cnt_inc == iters) begin
                                state               <= RED_ISSUE;
                                sq.o_sq_reduce_only <= 1'b1;
                            end else begin
                                state <= ISSUE;
                            end
                        end else if (wdog >= WD_LAST) begin
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    RED_ISSUE: begin
                        wdog  <= wdog + 1'b1;
                        state <= RED_WAIT;
                    end
                    RED_WAIT: begin
                        if (sq.i_sq_val) begin
                            o_dat  <= sq.i_sq_dat;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else if (wdog >= WD_LAST) begin
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    DONE: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vdf_sq_ctrl.sv
// Directed bench for vdf_sq_ctrl with a 5-cycle squarer model mod a
// 1024-bit modulus M = 2^1023 + 1.
module tb_vdf_sq_ctrl;
    localparam int WORD_BITS = 17;
    localparam int NUM_WORDS = 57;
    localparam int COEF_BITS = WORD_BITS + 1;
    localparam int I_WORD    = NUM_WORDS + 1;
    localparam int ITER_BITS = 32;
    localparam int TIMEOUT   = 64;
    localparam int DW        = I_WORD * COEF_BITS;
    localparam int LAT       = 5;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_abort = 1'b0;
    logic [ITER_BITS-1:0] i_iters = '0;
    logic [DW-1:0]        i_dat = '0;
    logic                 o_busy, o_done, o_err;
    logic [DW-1:0]        o_dat;
    logic [ITER_BITS-1:0] o_iter_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int iss_cnt = 0;
    int red_cnt = 0;
    logic model_en = 1'b1;
    logic model_clr = 1'b1;

    vdf_sq_ctrl_if #(.DAT_BITS(DW)) sq ();

    vdf_sq_ctrl #(
        .WORD_BITS (WORD_BITS),
        .NUM_WORDS (NUM_WORDS),
        .COEF_BITS (COEF_BITS),
        .I_WORD    (I_WORD),
        .ITER_BITS (ITER_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_iters    (i_iters),
        .i_dat      (i_dat),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_dat      (o_dat),
        .o_iter_cnt (o_iter_cnt),
        .sq         (sq)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] model_f(input logic [DW-1:0] x, input logic red);
        logic [2*DW-1:0] m;
        logic [2*DW-1:0] xw;
        logic [2*DW-1:0] p;
        m       = '0;
        m[1023] = 1'b1;
        m[0]    = 1'b1;
        xw      = {{DW{1'b0}}, x};
        p       = red ? xw : xw * xw;
        p       = p % m;
        return p[DW-1:0];
    endfunction

    // Squarer model: fixed LAT-cycle pipeline.
    logic          pv     [LAT];
    logic [DW-1:0] pv_dat [LAT];
    always @(posedge i_clk) begin
        if (model_clr) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i]     <= 1'b0;
                pv_dat[i] <= '0;
            end
        end else begin
            pv[0]     <= sq.o_sq_val & model_en;
            pv_dat[0] <= model_f(sq.o_sq_dat, sq.o_sq_reduce_only);
            for (int i = 1; i < LAT; i++) begin
                pv[i]     <= pv[i-1];
                pv_dat[i] <= pv_dat[i-1];
            end
        end
    end
    assign sq.i_sq_val = pv[LAT-1];
    assign sq.i_sq_dat = pv_dat[LAT-1];

    // Event counters.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (sq.o_sq_val && sq.o_sq_reduce_only) red_cnt <= red_cnt + 1;
        if (sq.o_sq_val && !sq.o_sq_reduce_only) iss_cnt <= iss_cnt + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [DW-1:0] x0, input int t);
        @(negedge i_clk);
        i_dat   = x0;
        i_iters = ITER_BITS'(t);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (o_done) seen = 1'b1;
            else @(negedge i_clk);
        end
        check({tag, "_done_seen"}, DW'(seen), DW'(1));
    endtask

    task automatic wait_rsp(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge i_clk);
            if (sq.i_sq_val) seen = 1'b1;
        end
        check({tag, "_rsp_seen"}, DW'(seen), DW'(1));
    endtask

    int b_done, b_iss, b_red, t0;
    bit seen_iss;

    initial begin
        repeat (3) @(negedge i_clk);
        model_clr = 1'b0;
        // Reset state
        check("rst_busy", DW'(o_busy), DW'(0));
        check("rst_done", DW'(o_done), DW'(0));
        check("rst_err", DW'(o_err), DW'(0));
        check("rst_dat", o_dat, '0);
        check("rst_cnt", DW'(o_iter_cnt), DW'(0));
        check("rst_sqval", DW'(sq.o_sq_val), DW'(0));
        check("rst_sqdat", sq.o_sq_dat, '0);
        i_rst = 1'b0;

        // Abort in IDLE has no effect
        @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("idle_abort_busy", DW'(o_busy), DW'(0));

        // x0=2, T=3 -> 256
        b_done = done_cnt; b_iss = iss_cnt; b_red = red_cnt;
        start_job(DW'(2), 3);
        check("t3_busy", DW'(o_busy), DW'(1));
        wait_done("t3", 200);
        check("t3_dat", o_dat, DW'(256));
        check("t3_cnt", DW'(o_iter_cnt), DW'(3));
        check("t3_err", DW'(o_err), DW'(0));
        @(negedge i_clk);
        check("t3_idle", DW'(o_busy), DW'(0));
        repeat (3) @(negedge i_clk);
        check("t3_ndone", DW'(done_cnt - b_done), DW'(1));
        check("t3_niss", DW'(iss_cnt - b_iss), DW'(3));
        check("t3_nred", DW'(red_cnt - b_red), DW'(1));

        // T=0, x0=5
        b_iss = iss_cnt; b_red = red_cnt;
        start_job(DW'(5), 0);
        check("t0_reduce", DW'(sq.o_sq_val & sq.o_sq_reduce_only), DW'(1));
        wait_done("t0", 100);
        check("t0_dat", o_dat, DW'(5));
        check("t0_cnt", DW'(o_iter_cnt), DW'(0));
        repeat (2) @(negedge i_clk);
        check("t0_niss", DW'(iss_cnt - b_iss), DW'(0));
        check("t0_nred", DW'(red_cnt - b_red), DW'(1));

        // Timeout with silent squarer
        model_en = 1'b0;
        start_job(DW'(7), 5);
        t0 = -1;
        seen_iss = 1'b0;
        for (int i = 0; i < 5 && !seen_iss; i++) begin
            if (sq.o_sq_val) begin
                seen_iss = 1'b1;
                t0 = cyc;
            end else @(negedge i_clk);
        end
        check("to_issue", DW'(seen_iss), DW'(1));
        wait_done("to", 200);
        check("to_latency", DW'(cyc - t0), DW'(TIMEOUT));
        check("to_err", DW'(o_err), DW'(1));
        check("to_dat", o_dat, DW'(5));
        repeat (4) @(negedge i_clk);
        check("to_err_hold", DW'(o_err), DW'(1));
        check("to_idle", DW'(o_busy), DW'(0));
        model_en = 1'b1;

        // Abort with second result of T=4
        b_done = done_cnt;
        start_job(DW'(2), 4);
        check("ab_err_clr", DW'(o_err), DW'(0));
        wait_rsp("ab1", 50);
        wait_rsp("ab2", 50);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("ab_idle", DW'(o_busy), DW'(0));
        check("ab_cnt", DW'(o_iter_cnt), DW'(1));
        repeat (10) @(negedge i_clk);
        check("ab_nodone", DW'(done_cnt - b_done), DW'(0));
        check("ab_dat", o_dat, DW'(5));
        check("ab_cnt_hold", DW'(o_iter_cnt), DW'(1));

        // Start pulsed while busy is ignored
        b_done = done_cnt;
        start_job(DW'(2), 2);
        repeat (2) @(negedge i_clk);
        i_dat = DW'(3); i_iters = '0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done("bs", 200);
        check("bs_dat", o_dat, DW'(16));
        check("bs_cnt", DW'(o_iter_cnt), DW'(2));
        repeat (3) @(negedge i_clk);
        check("bs_ndone", DW'(done_cnt - b_done), DW'(1));

        // Reset during WAIT; late result ignored
        b_done = done_cnt;
        start_job(DW'(2), 3);
        repeat (2) @(negedge i_clk);
        check("mr_busy", DW'(o_busy), DW'(1));
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mr_busy0", DW'(o_busy), DW'(0));
        check("mr_done0", DW'(o_done), DW'(0));
        check("mr_err0", DW'(o_err), DW'(0));
        check("mr_dat0", o_dat, '0);
        check("mr_cnt0", DW'(o_iter_cnt), DW'(0));
        check("mr_sqval0", DW'(sq.o_sq_val), DW'(0));
        check("mr_red0", DW'(sq.o_sq_reduce_only), DW'(0));
        check("mr_sqdat0", sq.o_sq_dat, '0);
        repeat (10) @(negedge i_clk);
        check("mr_late_busy", DW'(o_busy), DW'(0));
        check("mr_late_dat", o_dat, '0);
        check("mr_late_cnt", DW'(o_iter_cnt), DW'(0));
        check("mr_late_sqdat", sq.o_sq_dat, '0);
        check("mr_late_done", DW'(done_cnt - b_done), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/vdf_sq_ctrl.md
VDF_SQ_CTRL -- requirements
Module: vdf_sq_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 17, meaning bits per polynomial coefficient word.
REQ-002 The block SHALL have parameter NUM_WORDS, default 57, meaning number of modulus words.
REQ-003 The block SHALL have parameter COEF_BITS, default WORD_BITS+1, meaning redundant coefficient width.
REQ-004 The block SHALL have parameter I_WORD, default NUM_WORDS+1, meaning coefficients per operand.
REQ-005 The block SHALL have parameter ITER_BITS, default 32, meaning width of the iteration count.
REQ-006 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles to wait for a datapath result.
REQ-007 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port i_start, input, 1 bit: start-job pulse.
REQ-010 The block SHALL have port i_abort, input, 1 bit: cancel the current job.
REQ-011 The block SHALL have port i_iters, input, ITER_BITS: number of squarings T.
REQ-012 The block SHALL have port i_dat, input, I_WORD*COEF_BITS: initial operand x0.
REQ-013 The block SHALL have port o_busy, output, 1 bit: a job is in progress.
REQ-014 The block SHALL have port o_done, output, 1 bit: one-cycle job-complete pulse.
REQ-015 The block SHALL have port o_err, output, 1 bit: the last job timed out.
REQ-016 The block SHALL have port o_dat, output, I_WORD*COEF_BITS: final result.
REQ-017 The block SHALL have port o_iter_cnt, output, ITER_BITS: count of completed squarings.
REQ-018 The block SHALL have port o_sq_val, output, 1 bit: issue pulse to the squarer i_val.
REQ-019 The block SHALL have port o_sq_reduce_only, output, 1 bit: drives the squarer i_reduce_only.
REQ-020 The block SHALL have port o_sq_dat, output, I_WORD*COEF_BITS: operand to the squarer i_dat.
REQ-021 The block SHALL have port i_sq_val, input, 1 bit: squarer result valid (o_val).
REQ-022 The block SHALL have port i_sq_dat, input, I_WORD*COEF_BITS: squarer result (o_dat).

Function
REQ-023 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, RED_ISSUE, RED_WAIT, DONE.
REQ-024 In IDLE, i_start SHALL capture i_dat into the operand register, capture i_iters, clear o_iter_cnt and o_err, and go to ISSUE, or to RED_ISSUE if i_iters==0.
REQ-025 i_start SHALL be ignored in every state except IDLE.
REQ-026 ISSUE SHALL assert o_sq_val for exactly one cycle with o_sq_reduce_only=0, then go to WAIT.
REQ-027 o_sq_dat SHALL equal the operand register continuously; that register SHALL change only on an accepted start or a captured result.
REQ-028 In WAIT, i_sq_val SHALL capture i_sq_dat into the operand register and increment o_iter_cnt.
REQ-029 After the REQ-028 capture, the FSM SHALL go to RED_ISSUE if the new count equals T, else to ISSUE, so the next o_sq_val occurs 1 cycle after i_sq_val.
REQ-030 RED_ISSUE SHALL pulse o_sq_val with o_sq_reduce_only=1 for one cycle, then go to RED_WAIT.
REQ-031 In RED_WAIT, i_sq_val SHALL capture i_sq_dat into o_dat and go to DONE; o_iter_cnt SHALL NOT increment.
REQ-032 DONE SHALL assert o_done for one cycle, then return to IDLE.
REQ-033 o_dat SHALL hold its value until the next DONE.
REQ-034 o_busy SHALL be 1 in every state except IDLE.
REQ-035 i_sq_val SHALL be ignored in IDLE, ISSUE, RED_ISSUE and DONE.
REQ-036 A watchdog SHALL count cycles spent in WAIT or RED_WAIT and clear on every issue.
REQ-037 When the watchdog reaches TIMEOUT, the block SHALL set o_err=1 and go to DONE; o_dat SHALL be unchanged and o_err SHALL hold until the next accepted start.
REQ-038 i_abort in any non-IDLE state SHALL force IDLE on the next cycle with no o_done; o_dat, o_err and o_iter_cnt SHALL hold.
REQ-039 If i_abort and i_sq_val arrive in the same cycle, abort SHALL win and the result SHALL NOT be captured.
REQ-040 i_abort in IDLE SHALL have no effect.
REQ-041 o_iter_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-042 On i_rst, the block SHALL enter IDLE.
REQ-043 On i_rst, o_busy, o_done, o_err, o_sq_val and o_sq_reduce_only SHALL be 0.
REQ-044 On i_rst, o_dat, o_iter_cnt, the operand register and the watchdog SHALL be 0.
REQ-045 Reset asserted mid-job SHALL take effect on the next clock edge, and a result arriving afterwards SHALL be ignored.

Verification
REQ-046 Use a squarer model with 5-cycle latency and the 1024-bit modulus M. Scenario: x0=2, T=3 -> three o_sq_val pulses with reduce_only=0 and one with reduce_only=1; o_done once; o_dat ≡ 256 mod M; o_iter_cnt=3; o_err=0.
REQ-047 Scenario: T=0, x0=5 -> a single reduce-only issue; o_dat ≡ 5; o_iter_cnt=0.
REQ-048 Scenario: TIMEOUT=64 with the model never answering -> o_done and o_err exactly 64 cycles after the issue; o_dat unchanged.
REQ-049 Scenario: i_abort in the same cycle as the second i_sq_val of T=4 -> IDLE next cycle; no o_done; o_iter_cnt=1.
REQ-050 Scenario: i_start pulsed while busy -> ignored; T=2 completes with o_dat ≡ 16 for x0=2.
REQ-051 Scenario: i_rst asserted during WAIT -> all outputs 0 the next cycle; a late i_sq_val is ignored.
